// File: rtl/uart_tx_feeder_if.sv
// Byte write port of the UART TX feeder: valid/ready handshake carrying one byte.
interface uart_tx_feeder_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  // Producer side drives data/valid, sees ready.
  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  // Feeder side consumes data/valid, drives ready.
  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// UART TX feeder: byte FIFO that launches one frame per stored byte towards the
// bit-select stage. tx_data is held for the whole frame and only changes on a pop.
module uart_tx_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_feeder_if.slave    wr_if,
  input  logic               flush,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               tx_en,
  output logic [DATA_W-1:0]  tx_data,
  output logic [ADDR_W:0]    fifo_count,
  output logic               fifo_empty,
  output logic               fifo_full
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [1:0]        state_q, state_d;
  logic              tx_en_q, tx_en_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              push_s;
  logic              pop_s;

  // Ready depends only on the registered full flag, so a same-cycle pop never frees a slot.
  assign wr_if.wr_ready = ~full_q;
  assign tx_en          = tx_en_q;
  assign tx_data        = tx_data_q;
  assign fifo_count     = count_q;
  assign fifo_empty     = empty_q;
  assign fifo_full      = full_q;

  // Frame sequencing: decide when to pop the head byte and where the FSM goes next.
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && !tx_busy) begin
          pop_s   = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          if (!empty_q) begin
            pop_s   = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    tx_en_d = (state_d == S_START);
    if (pop_s) begin
      tx_data_d = mem_q[rd_ptr_q];
    end else begin
      tx_data_d = tx_data_q;
    end
  end

  // Queue bookkeeping: pointers, occupancy and the registered empty/full flags.
  always_comb begin
    push_s   = wr_if.wr_valid & ~full_q & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {ADDR_W{1'b0}};
      rd_ptr_d = {ADDR_W{1'b0}};
      count_d  = {(ADDR_W + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
    empty_d = (count_d == {(ADDR_W + 1){1'b0}});
    full_d  = (count_d == (ADDR_W + 1)'(DEPTH));
  end

  // Byte storage: written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_if.wr_data;
    end
  end

  // State registers with synchronous reset; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= {ADDR_W{1'b0}};
      rd_ptr_q  <= {ADDR_W{1'b0}};
      count_q   <= {(ADDR_W + 1){1'b0}};
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      state_q   <= S_IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= {DATA_W{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule
